// File: rtl/pocket_scan_scheduler_pkg.sv
// Shared types and constants for the pocket scan scheduler and its distance pipeline.
// Optional early-exit behaviour is selected with POCKET_SCAN_EARLY_EXIT_EN.
package pocket_scan_scheduler_pkg;

  localparam int N_BALLS      = 5;
  localparam int N_POCKETS    = 6;
  localparam int COORD_W      = 11;
  localparam int DIFF_W       = 12;
  localparam int DSQ_W        = 23;
  localparam int BALL_IDX_W   = 3;
  localparam int POCKET_IDX_W = 3;

  localparam logic [DSQ_W-1:0] DISTANCE_SQUARED = 23'd1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Widening subtract so the full coordinate span never wraps.
  function automatic logic signed [DIFF_W-1:0] coord_diff(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b
  );
    logic signed [DIFF_W-1:0] a_ext;
    logic signed [DIFF_W-1:0] b_ext;
    a_ext = DIFF_W'(a);
    b_ext = DIFF_W'(b);
    return a_ext - b_ext;
  endfunction

endpackage

// File: rtl/pocket_scan_scheduler_dist_sq_pipe.sv
// Two-stage subtract / square-and-sum pipeline; the ball tag and valid bit ride along.
// Used identically with and without POCKET_SCAN_EARLY_EXIT_EN.
module dist_sq_pipe
  import pocket_scan_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [BALL_IDX_W-1:0]       issue_tag,
  input  logic signed [COORD_W-1:0]   ball_x,
  input  logic signed [COORD_W-1:0]   ball_y,
  input  logic signed [COORD_W-1:0]   pocket_x,
  input  logic signed [COORD_W-1:0]   pocket_y,
  output logic                        res_valid,
  output logic [BALL_IDX_W-1:0]       res_tag,
  output logic [DSQ_W-1:0]            res_dsq
);

  logic                      s1_valid;
  logic [BALL_IDX_W-1:0]     s1_tag;
  logic signed [DIFF_W-1:0]  s1_dx;
  logic signed [DIFF_W-1:0]  s1_dy;

  logic [DSQ_W-1:0] dx_ext;
  logic [DSQ_W-1:0] dy_ext;
  logic [DSQ_W-1:0] sq_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
    end else begin
      s1_valid <= issue_valid;
      s1_tag   <= issue_tag;
      s1_dx    <= coord_diff(pocket_x, ball_x);
      s1_dy    <= coord_diff(pocket_y, ball_y);
    end
  end

  // Squares are taken modulo 2^DSQ_W on sign-extended operands; the true sum
  // always fits in DSQ_W bits, so the low bits are exact.
  always_comb begin
    dx_ext = {{(DSQ_W-DIFF_W){s1_dx[DIFF_W-1]}}, s1_dx};
    dy_ext = {{(DSQ_W-DIFF_W){s1_dy[DIFF_W-1]}}, s1_dy};
    sq_sum = (dx_ext * dx_ext) + (dy_ext * dy_ext);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_dsq   <= '0;
    end else begin
      res_valid <= s1_valid;
      res_tag   <= s1_tag;
      res_dsq   <= sq_sum;
    end
  end

endmodule

// File: rtl/pocket_scan_scheduler.sv
// Frame-based scheduler that scans every (active ball, pocket) pair through one shared
// distance pipeline. Define POCKET_SCAN_EARLY_EXIT_EN to skip a ball's remaining pockets on a hit.
module pocket_scan_scheduler
  import pocket_scan_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic [N_BALLS-1:0]          ball_active,
  output logic [BALL_IDX_W-1:0]       ball_idx,
  output logic [POCKET_IDX_W-1:0]     pocket_idx,
  input  logic signed [COORD_W-1:0]   ball_x,
  input  logic signed [COORD_W-1:0]   ball_y,
  input  logic signed [COORD_W-1:0]   pocket_x,
  input  logic signed [COORD_W-1:0]   pocket_y,
  output logic                        busy,
  output logic                        done,
  output logic [N_BALLS-1:0]          ball_in,
  output logic                        overrun,
  output scan_state_t                 scan_state
);

  // Handshake: frame_start is a request pulse honoured only in IDLE; done is a
  // one-cycle completion pulse and ball_in stays valid until the next done.

  scan_state_t            state;
  scan_state_t            state_next;
  logic [N_BALLS-1:0]     snap;
  logic [N_BALLS-1:0]     hit_acc;
  logic                   drain_cnt;

  logic                   res_valid;
  logic [BALL_IDX_W-1:0]  res_tag;
  logic [DSQ_W-1:0]       res_dsq;

  logic                   issue_valid;
  logic                   hit_now;
  logic [N_BALLS-1:0]     hit_merged;
  logic                   last_pocket;
  logic                   advance_ball;
  logic                   accept;
  logic                   first_found;
  logic [BALL_IDX_W-1:0]  first_idx;
  logic                   nxt_found;
  logic [BALL_IDX_W-1:0]  nxt_idx;

  // Lowest set bit of mask at or above start; found is 0 when none remain.
  function automatic logic [BALL_IDX_W:0] lowest_from(
    input logic [N_BALLS-1:0] mask,
    input int                 start
  );
    logic                  found;
    logic [BALL_IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) begin
        found = 1'b1;
        idx   = BALL_IDX_W'(i);
      end
    end
    return {found, idx};
  endfunction

  dist_sq_pipe u_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_tag   (ball_idx),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .pocket_x    (pocket_x),
    .pocket_y    (pocket_y),
    .res_valid   (res_valid),
    .res_tag     (res_tag),
    .res_dsq     (res_dsq)
  );

  always_comb begin
    issue_valid = (state == ISSUE);
    accept      = (state == IDLE) && frame_start;
    hit_now     = res_valid && (res_dsq <= DISTANCE_SQUARED);
    hit_merged  = hit_acc;
    if (hit_now) begin
      hit_merged = hit_acc | (N_BALLS'(1) << res_tag);
    end
    last_pocket = (pocket_idx == POCKET_IDX_W'(N_POCKETS - 1));
`ifdef POCKET_SCAN_EARLY_EXIT_EN
    advance_ball = last_pocket || (hit_now && (res_tag == ball_idx));
`else
    advance_ball = last_pocket;
`endif
    {first_found, first_idx} = lowest_from(ball_active, 0);
    {nxt_found, nxt_idx}     = lowest_from(snap, int'(ball_idx) + 1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (frame_start) state_next = first_found ? ISSUE : DRAIN;
      ISSUE: if (advance_ball && !nxt_found) state_next = DRAIN;
      DRAIN: if (drain_cnt) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap       <= '0;
      hit_acc    <= '0;
      ball_in    <= '0;
      ball_idx   <= '0;
      pocket_idx <= '0;
      drain_cnt  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_start && (state != IDLE);
      hit_acc <= accept ? '0 : hit_merged;
      case (state)
        IDLE: begin
          if (frame_start) begin
            snap       <= ball_active;
            ball_idx   <= first_idx;
            pocket_idx <= '0;
            drain_cnt  <= 1'b0;
          end
        end
        ISSUE: begin
          if (advance_ball) begin
            pocket_idx <= '0;
            if (nxt_found) ball_idx <= nxt_idx;
          end else begin
            pocket_idx <= pocket_idx + POCKET_IDX_W'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          // The final pipeline result is still in stage 2 here, so merge it in.
          if (drain_cnt) ball_in <= hit_merged & snap;
        end
        DONE: drain_cnt <= 1'b0;
        default: drain_cnt <= 1'b0;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign scan_state = state;

endmodule
